// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB request arbiter: state encoding,
// strobe-width derivation and packed-bus slice offsets.
package apb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StReq    = 2'b01,
    StSetup  = 2'b10,
    StAccess = 2'b11
  } arb_state_e;

  function automatic int unsigned strb_width(input int unsigned data_width);
    return data_width / 8;
  endfunction

  // Low bit of element idx in a packed bus of width-bit elements.
  function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

// File: rtl/apb_req_arbiter_if.sv
// Arbiter-to-APB-master command/completion bundle.
interface apb_req_arbiter_if
  import apb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAIN_ADDR_WIDTH = 32,
  localparam int unsigned STRB_WIDTH     = strb_width(DATA_WIDTH)
);

  logic                       transfer;
  logic [MAIN_ADDR_WIDTH-1:0] APB_ADDR;
  logic [DATA_WIDTH-1:0]      APB_WDATA;
  logic [STRB_WIDTH-1:0]      APB_STRB;
  logic                       APB_WRITE;
  logic                       APB_PREADY;
  logic [DATA_WIDTH-1:0]      APB_RDATA;

  // The arbiter drives commands; the APB master answers with ready/data.
  modport master (
    output transfer, APB_ADDR, APB_WDATA, APB_STRB, APB_WRITE,
    input  APB_PREADY, APB_RDATA
  );

  modport slave (
    input  transfer, APB_ADDR, APB_WDATA, APB_STRB, APB_WRITE,
    output APB_PREADY, APB_RDATA
  );

endinterface

// File: rtl/apb_rr_picker.sv
// Combinational round-robin picker: first active request after ptr, wrapping.
module apb_rr_picker #(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [IDX_WIDTH-1:0] ptr,
  output logic [IDX_WIDTH-1:0] winner,
  output logic                 valid
);

  assign valid = |req;

  // Walk from the farthest candidate back to ptr+1 so the nearest one wins.
  always_comb begin
    winner = '0;
    for (int i = int'(NUM_REQ); i > 0; i--) begin
      if (req[(int'(ptr) + i) % int'(NUM_REQ)]) begin
        winner = IDX_WIDTH'((int'(ptr) + i) % int'(NUM_REQ));
      end
    end
  end

endmodule

// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter sharing one APB master among NUM_REQ requesters;
// latches the winner's command and returns completion/read data to it.
module apb_req_arbiter
  import apb_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned MAIN_ADDR_WIDTH = 32,
  localparam int unsigned STRB_WIDTH     = strb_width(DATA_WIDTH),
  localparam int unsigned IDX_WIDTH      = $clog2(NUM_REQ)
) (
  input  logic                               PCLK,
  input  logic                               PRESET_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ-1:0]                 req_write,
  input  logic [NUM_REQ*MAIN_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_wdata,
  input  logic [NUM_REQ*STRB_WIDTH-1:0]      req_strb,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic [NUM_REQ-1:0]                 done,
  output logic [DATA_WIDTH-1:0]              rdata,
  output logic                               busy,
  output logic [IDX_WIDTH-1:0]               owner,
  apb_req_arbiter_if.master                  apb
);

  arb_state_e                 state_q, state_d;
  logic [IDX_WIDTH-1:0]       ptr_q, ptr_d, owner_q, owner_d;
  logic [NUM_REQ-1:0]         gnt_q, gnt_d, done_q, done_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       busy_q, transfer_q, transfer_d;
  logic [MAIN_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]      strb_q, strb_d;
  logic                       write_q, write_d;

  logic [IDX_WIDTH-1:0]       pick_idx;
  logic                       pick_valid;
  int unsigned                pick_u;

  apb_rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

  assign pick_u = 32'(pick_idx);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    strb_d     = strb_q;
    write_d    = write_q;
    gnt_d      = '0;
    done_d     = '0;
    rdata_d    = '0;
    transfer_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          addr_d  = req_addr[slice_lo(pick_u, MAIN_ADDR_WIDTH) +: MAIN_ADDR_WIDTH];
          wdata_d = req_wdata[slice_lo(pick_u, DATA_WIDTH) +: DATA_WIDTH];
          write_d = req_write[pick_idx];
          // Reads never carry byte strobes.
          strb_d  = req_write[pick_idx] ? req_strb[slice_lo(pick_u, STRB_WIDTH) +: STRB_WIDTH]
                                        : '0;
          owner_d = pick_idx;
          ptr_d   = pick_idx;
          gnt_d[pick_idx] = 1'b1;
          transfer_d      = 1'b1;
          state_d         = StReq;
        end
      end
      StReq:   state_d = StSetup;
      StSetup: state_d = StAccess;
      StAccess: begin
        if (apb.APB_PREADY) begin
          done_d[owner_q] = 1'b1;
          rdata_d         = apb.APB_RDATA;
          state_d         = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESET_n) begin
    if (!PRESET_n) begin
      state_q    <= StIdle;
      ptr_q      <= IDX_WIDTH'(NUM_REQ - 1);
      owner_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      strb_q     <= '0;
      write_q    <= 1'b0;
      gnt_q      <= '0;
      done_q     <= '0;
      rdata_q    <= '0;
      transfer_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      strb_q     <= strb_d;
      write_q    <= write_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      rdata_q    <= rdata_d;
      transfer_q <= transfer_d;
      busy_q     <= (state_d != StIdle);
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign busy          = busy_q;
  assign owner         = owner_q;
  assign apb.transfer  = transfer_q;
  assign apb.APB_ADDR  = addr_q;
  assign apb.APB_WDATA = wdata_q;
  assign apb.APB_STRB  = strb_q;
  assign apb.APB_WRITE = write_q;

endmodule
